mips_fetch: RTL

Parametrised instruction-fetch unit for the multicycle MIPS core. It replaces the fixed four-state byte fetch with a handshaked unit that assembles a 32-bit instruction from WIDTH-bit memory beats, tolerates memory wait states, and accepts branch/jump redirects at any cycle. A single buffered instruction is handed to the controller over a valid/ready interface.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mips_fetch_if.sv | 28 ++
 rtl/flopenr.sv | 22 ++
 rtl/mips_fetch_ir_assembler.sv | 37 +++
 rtl/mips_fetch.sv | 129 ++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS fetch path.
package mips_pkg;

  localparam int INSTR_BITS = 32;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Number of memory beats needed to build one instruction.
  function automatic int beats(input int width);
    return INSTR_BITS / width;
  endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Memory-side and consumer-side signal bundle of the fetch unit.
interface mips_fetch_if #(
  parameter int WIDTH = 8
) ();

  logic                             mem_req;
  logic [WIDTH-1:0]                 mem_adr;
  logic                             mem_ready;
  logic [WIDTH-1:0]                 mem_rdata;
  logic                             redirect;
  logic [WIDTH-1:0]                 redirect_pc;
  logic [mips_pkg::INSTR_BITS-1:0]  instr;
  logic [WIDTH-1:0]                 instr_pc;
  logic                             instr_valid;
  logic                             instr_ready;
  logic                             busy;

  modport master (
    output mem_req, mem_adr, instr, instr_pc, instr_valid, busy,
    input  mem_ready, mem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_adr, instr, instr_pc, instr_valid, busy,
    output mem_ready, mem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-high reset to a parameter value.
module flopenr #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load on enable, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/mips_fetch_ir_assembler.sv
// Instruction register built from BEATS lanes; lane 0 is the most significant.
module ir_assembler
  import mips_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BEATS = beats(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [CNT_W-1:0]      i_idx,
  input  logic [WIDTH-1:0]      i_data,
  output logic [INSTR_BITS-1:0] o_instr
);

  logic [WIDTH-1:0] r_lane [BEATS];

  // Write the addressed lane when a beat is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < BEATS; k++) begin
        r_lane[k] <= '0;
      end
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (i_we && (i_idx == CNT_W'(k))) begin
          r_lane[k] <= i_data;
        end
      end
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_lane
    assign o_instr[INSTR_BITS-1-g*WIDTH -: WIDTH] = r_lane[g];
  end

endmodule

// File: rtl/mips_fetch.sv
// Handshaked instruction fetch: assembles 32-bit words from WIDTH-bit beats,
// absorbs memory wait states and accepts redirects in any state.
module mips_fetch
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  mips_fetch_if.master bus
);

  localparam int               BEATS      = beats(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(WIDTH / 8);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [WIDTH-1:0]      r_pc;
  logic [WIDTH-1:0]      w_pc_nxt;
  logic                  w_pc_en;
  logic                  w_accept;
  logic                  w_keep_beat;
  logic                  r_mem_req;
  logic                  r_instr_valid;
  logic [WIDTH-1:0]      r_instr_pc;
  logic [INSTR_BITS-1:0] w_instr;

  assign w_accept    = (r_state == FETCH) && bus.mem_ready;
  // A beat landing together with a redirect belongs to the squashed stream.
  assign w_keep_beat = w_accept && !bus.redirect;

  // Next state, beat counter and pc update; redirect overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc + PC_STEP;
    w_pc_en     = 1'b0;
    if (bus.redirect) begin
      w_state_nxt = FETCH;
      w_cnt_nxt   = '0;
      w_pc_nxt    = bus.redirect_pc & ALIGN_MASK;
      w_pc_en     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = FETCH;
        end
        FETCH: begin
          if (bus.mem_ready) begin
            w_pc_en = 1'b1;
            if (r_cnt == LAST_BEAT) begin
              w_cnt_nxt   = '0;
              w_state_nxt = HOLD;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nxt = FETCH;
          end
        end
        HOLD: begin
          if (r_instr_valid && bus.instr_ready) begin
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= RESET_PC;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mem_req     <= (w_state_nxt == FETCH);
      r_instr_valid <= (w_state_nxt == HOLD);
      if (w_keep_beat && (r_cnt == '0)) begin
        r_instr_pc <= r_pc;
      end
    end
  end

  flopenr #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_pc_en),
    .i_d   (w_pc_nxt),
    .o_q   (r_pc)
  );

  ir_assembler #(
    .WIDTH (WIDTH),
    .BEATS (BEATS)
  ) u_ir (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_keep_beat),
    .i_idx   (r_cnt),
    .i_data  (bus.mem_rdata),
    .o_instr (w_instr)
  );

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_adr     = r_pc;
  assign bus.busy        = r_mem_req;
  assign bus.instr       = w_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;

endmodule
